// File: rtl/sine_rom_reader.sv
`default_nettype none
// sine_rom_reader: DDS-addressed burst reader for a 1-cycle-latency ROM,
// with a 2-entry skid FIFO feeding a valid/ready stream.  rev 1.0
module sine_rom_reader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 12,
  parameter int PHASE_WIDTH = 24,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PHASE_WIDTH-1:0] freq_word,
  input  logic [CNT_WIDTH-1:0]   num_samples,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_rd_data,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   dout_last,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [PHASE_WIDTH-1:0] phase, inc;
  logic [CNT_WIDTH-1:0]   remaining, out_cnt;
  logic [1:0]             fifo_cnt;
  logic                   inflight;
  logic [DATA_WIDTH-1:0]  q0, q1;

  logic       start_ok, pop, issue, abort;
  logic [2:0] occ_next;

  assign start_ok   = (state == IDLE) && start;
  assign dout_valid = (fifo_cnt != 2'd0);
  assign pop        = dout_valid && dout_ready;
  // Occupancy the FIFO will have once this cycle's pop and capture settle.
  assign occ_next   = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign abort      = stop && ((state == RUN) || (state == DRAIN));
  assign issue      = (state == RUN) && !stop && (remaining != '0) && (occ_next < 3'd2);

  assign rom_addr  = phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign dout      = q0;
  assign dout_last = dout_valid && (out_cnt == CNT_WIDTH'(1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = DONE;
        end else if (remaining == '0) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (stop || (occ_next == 3'd0)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      inc       <= '0;
      remaining <= '0;
      out_cnt   <= '0;
      fifo_cnt  <= 2'd0;
      inflight  <= 1'b0;
      q0        <= '0;
      q1        <= '0;
    end else begin
      state <= state_next;

      if (start_ok) begin
        phase     <= '0;
        inc       <= freq_word;
        remaining <= num_samples;
      end else if (issue) begin
        phase     <= phase + inc;
        remaining <= remaining - CNT_WIDTH'(1);
      end

      if (start_ok) begin
        out_cnt <= num_samples;
      end else if (pop) begin
        out_cnt <= out_cnt - CNT_WIDTH'(1);
      end

      inflight <= abort ? 1'b0 : issue;

      // Data still in the ROM pipe on abort is simply never captured.
      if (abort) begin
        fifo_cnt <= 2'd0;
      end else begin
        case ({inflight, pop})
          2'b11: begin
            if (fifo_cnt == 2'd1) begin
              q0 <= rom_rd_data;
            end else begin
              q0 <= q1;
              q1 <= rom_rd_data;
            end
          end
          2'b01: begin
            q0       <= q1;
            fifo_cnt <= fifo_cnt - 2'd1;
          end
          2'b10: begin
            if (fifo_cnt == 2'd0) begin
              q0 <= rom_rd_data;
            end else begin
              q1 <= rom_rd_data;
            end
            fifo_cnt <= fifo_cnt + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sine_rom_reader.sv
`default_nettype none
// tb_sine_rom_reader: directed self-checking bench with a behavioural ROM.
module tb_sine_rom_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [23:0] freq_word = '0;
  logic [15:0] num_samples = '0;
  logic [9:0]  rom_addr;
  logic [11:0] rom_rd_data = '0;
  logic [11:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        dout_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  sine_rom_reader #(
    .ADDR_WIDTH(10), .DATA_WIDTH(12), .PHASE_WIDTH(24), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .freq_word(freq_word), .num_samples(num_samples),
    .rom_addr(rom_addr), .rom_rd_data(rom_rd_data),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input int a);
    int v;
    v = (a * 37 + 100) & 32'hfff;
    return v[11:0];
  endfunction

  // Registered-address ROM with one cycle of read latency.
  always @(posedge clk) rom_rd_data <= rom_f(int'(rom_addr));

  logic [11:0] got[$];
  bit          lasts[$];
  int          first_valid, done_cyc, last_hs, unstable, busy_at_done;
  int          addr_log[8];

  task automatic start_burst(input logic [23:0] f, input logic [15:0] n);
    @(negedge clk);
    start = 1'b1; freq_word = f; num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observe one burst from the cycle after acceptance; index 0 is that cycle.
  task automatic collect(input bit bp, input int max_cyc);
    bit          prev_stall;
    logic [11:0] prev_dout;
    got.delete(); lasts.delete();
    first_valid = -1; done_cyc = -1; last_hs = -1; unstable = 0; busy_at_done = -1;
    prev_stall = 1'b0; prev_dout = '0;
    for (int i = 0; i < 8; i++) addr_log[i] = -1;
    for (int c = 0; c < max_cyc; c++) begin
      dout_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c < 8) addr_log[c] = int'(rom_addr);
      if (prev_stall && (!dout_valid || dout !== prev_dout)) unstable++;
      if (dout_valid && first_valid < 0) first_valid = c;
      if (dout_valid && dout_ready) begin
        got.push_back(dout); lasts.push_back(dout_last); last_hs = c;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      if (done) begin
        done_cyc = c; busy_at_done = int'(busy);
        break;
      end
      @(negedge clk);
    end
    dout_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dout, dout_valid, dout_last, busy, done, rom_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got dout=%h v=%b l=%b busy=%b done=%b addr=%0d, need all 0",
               dout, dout_valid, dout_last, busy, done, rom_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    start_burst(24'h004000, 16'd4);
    collect(1'b0, 50);
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL basic_count: got %0d need 4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== rom_f(k) || lasts[k] !== (k == 3)) begin
        errors++;
        $display("FAIL basic_sample%0d: got %h last=%b need %h last=%b", k, got[k], lasts[k], rom_f(k), k == 3);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (addr_log[k] != k) begin
        errors++; $display("FAIL basic_addr%0d: got %0d need %0d", k, addr_log[k], k);
      end
    end
    checks++;
    if (first_valid != 2 || last_hs != 5 || done_cyc != 6 || busy_at_done != 1) begin
      errors++;
      $display("FAIL basic_timing: first_valid=%0d last_hs=%0d done=%0d busy=%0d need 2 5 6 1",
               first_valid, last_hs, done_cyc, busy_at_done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: busy=%b done=%b need 0 0", busy, done);
    end
  endtask

  task automatic test_wrap;
    int bad;
    start_burst(24'h100000, 16'd20);
    collect(1'b0, 100);
    bad = 0;
    for (int k = 0; k < got.size(); k++)
      if (got[k] !== rom_f((k * 64) % 1024) || lasts[k] !== (k == 19)) bad++;
    checks++;
    if (got.size() != 20 || bad != 0 || done_cyc != last_hs + 1) begin
      errors++;
      $display("FAIL wrap_seq: count=%0d bad=%0d done=%0d last_hs=%0d need 20 0 last_hs+1",
               got.size(), bad, done_cyc, last_hs);
    end
    checks++;
    if (addr_log[0] != 0 || addr_log[1] != 64 || addr_log[7] != 448) begin
      errors++;
      $display("FAIL wrap_addr: got %0d %0d %0d need 0 64 448", addr_log[0], addr_log[1], addr_log[7]);
    end
  endtask

  task automatic test_backpressure;
    int bad;
    start_burst(24'h00C000, 16'd16);
    collect(1'b1, 400);
    bad = 0;
    for (int k = 0; k < got.size(); k++)
      if (got[k] !== rom_f(k * 3) || lasts[k] !== (k == 15)) bad++;
    checks++;
    if (got.size() != 16 || bad != 0) begin
      errors++; $display("FAIL bp_seq: count=%0d bad=%0d need 16 0", got.size(), bad);
    end
    checks++;
    if (unstable != 0 || done_cyc != last_hs + 1) begin
      errors++;
      $display("FAIL bp_stall: unstable=%0d done=%0d last_hs=%0d need 0, last_hs+1", unstable, done_cyc, last_hs);
    end
  endtask

  task automatic test_empty;
    start_burst(24'h004000, 16'd0);
    collect(1'b0, 20);
    checks++;
    if (done_cyc != 0 || first_valid != -1 || got.size() != 0) begin
      errors++;
      $display("FAIL empty_burst: done=%0d first_valid=%0d count=%0d need 0 -1 0", done_cyc, first_valid, got.size());
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL empty_after: busy=%b done=%b valid=%b need 0 0 0", busy, done, dout_valid);
    end
  endtask

  task automatic test_abort;
    int hs, bad, dones, guard;
    start_burst(24'h004000, 16'd100);
    hs = 0; bad = 0; guard = 0;
    dout_ready = 1'b1;
    while (hs < 10 && guard < 100) begin
      if (dout_valid && dout_ready) begin
        if (dout !== rom_f(hs)) bad++;
        hs++;
      end
      guard++;
      @(negedge clk);
    end
    stop = 1'b1; dout_ready = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (hs != 10 || bad != 0) begin
      errors++; $display("FAIL abort_prefix: handshakes=%0d bad=%0d need 10 0", hs, bad);
    end
    checks++;
    if (dout_valid !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL abort_stop: valid=%b done=%b need 0 1", dout_valid, done);
    end
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (dout_valid) bad++;
    end
    checks++;
    if (dones != 0 || bad != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_settle: extra_done=%0d stray_valid=%0d busy=%b need 0 0 0", dones, bad, busy);
    end
    start_burst(24'h004000, 16'd4);
    collect(1'b0, 50);
    checks++;
    if (addr_log[0] != 0 || got.size() != 4 || got[0] !== rom_f(0) || got[3] !== rom_f(3)) begin
      errors++;
      $display("FAIL abort_restart: addr0=%0d count=%0d first=%h need 0 4 %h", addr_log[0], got.size(), got[0], rom_f(0));
    end
  endtask

  task automatic test_start_ignored;
    int bad;
    start_burst(24'h004000, 16'd8);
    start = 1'b1; freq_word = 24'h008000; num_samples = 16'd3;
    @(negedge clk);
    start = 1'b0;
    collect(1'b0, 60);
    bad = 0;
    for (int k = 0; k < got.size(); k++)
      if (got[k] !== rom_f(k) || lasts[k] !== (k == 7)) bad++;
    checks++;
    if (got.size() != 8 || bad != 0) begin
      errors++; $display("FAIL start_while_busy: count=%0d bad=%0d need 8 0", got.size(), bad);
    end
  endtask

  task automatic test_reset_mid;
    start_burst(24'h004000, 16'd50);
    dout_ready = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; dout_ready = 1'b0;
    checks++;
    if ({dout, dout_valid, dout_last, busy, done, rom_addr} !== '0) begin
      errors++;
      $display("FAIL reset_mid: dout=%h v=%b l=%b busy=%b done=%b addr=%0d need all 0",
               dout, dout_valid, dout_last, busy, done, rom_addr);
    end
    start_burst(24'h004000, 16'd2);
    collect(1'b0, 40);
    checks++;
    if (got.size() != 2 || got[0] !== rom_f(0) || lasts[1] !== 1'b1) begin
      errors++; $display("FAIL reset_recover: count=%0d first=%h need 2 %h", got.size(), got[0], rom_f(0));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_empty();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
